bcd_serial_adder_ctrl: RTL and testbench
========================================

# bcd_serial_adder_ctrl

Sequencing controller that adds two multi-digit BCD operands using one shared 4-bit ripple adder, one decimal digit per clock, least-significant digit first. Sits between the switch/operand registers and the seven-segment decode stage. It replaces the purely combinational single-digit add path with a start/busy/done handshake so wide BCD sums reuse one adder slice.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand, ≥1.
- `CLOCK_50`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request an add. Sampled only in IDLE.
- `a`  in  4*DIGITS: operand A, packed BCD; digit i = `a[4i+3:4i]`.
- `b`  in  4*DIGITS: operand B, same packing.
- `busy`  out  1: high from the LOAD cycle through the last ADD cycle.
- `done`  out  1: single-cycle pulse when `sum`, `cout` and `err` are valid.
- `sum`  out  4*DIGITS: packed BCD result. Held until the next LOAD.
- `cout`  out  1: decimal carry out of the most-significant digit.
- `err`  out  1: any operand digit was greater than 9 at LOAD.

## Operation
- States: IDLE, LOAD, ADD, DONE. Binary encoding, 2 bits.
- **IDLE**
  - `start`=1 → LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - Capture `a` and `b` into shift registers.
  - Clear the digit index, the carry register and `sum`.
  - Evaluate the digit-validity check on the captured values.
  - If any digit > 9: set `err`=1, `sum` = all 4'hF (blank code for the HEX decoder), `cout`=0, then → DONE.
  - Else: `err`=0, then → ADD.
- **ADD**, one digit per cycle:
  - Raw sum: raw = A_i + B_i + c, 5 bits.
  - If raw > 9: digit = (raw + 6) mod 16, carry = 1.
  - Else: digit = raw[3:0], carry = 0.
  - Write the digit into `sum` slot i and register the carry.
  - After digit DIGITS−1: `cout` = final carry, then → DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then → IDLE.
- Any `start` outside IDLE is ignored (no queueing).
- Operands are sampled only at LOAD. Changes to `a`/`b` after LOAD do not affect the result.
- Reset values:
  - state=IDLE
  - `busy`=0, `done`=0
  - `sum`=0, `cout`=0, `err`=0
  - digit index=0, carry=0
- Reset asserted mid-operation aborts immediately. The partial result is discarded and all outputs take their reset values.

## Timing
- Clock edge t0: `start`=1 sampled in IDLE.
- Cycle t0+1: LOAD, `busy`=1.
- Cycles t0+2 … t0+1+DIGITS: ADD, `busy`=1.
- Cycle t0+2+DIGITS: DONE, `done`=1, `busy`=0. Result is valid in this cycle and stays stable afterward.
- Latency from `start` to `done` = DIGITS+2 cycles (6 for DIGITS=4).
- Error path: `done` at t0+2, latency 2 cycles.
- `start` held high continuously: a new operation begins on the cycle after DONE returns to IDLE. Back-to-back period = DIGITS+3 cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `bcd_pkg` holds:
  - state encodings `ST_IDLE`=0, `ST_LOAD`=1, `ST_ADD`=2, `ST_DONE`=3;
  - `BCD_MAX`=9 and `BCD_ADJ`=6;
  - the seven-segment constants `SEG0`…`SEG9` and `SEG_BLANK`=7'b1111111, for the downstream HEX decode.
- One sub-module: `bcd_digit_adder`.
  - Combinational.
  - Contains the existing 4-bit ripple `full_adder` slice plus the >9 detect and +6 correction.
  - Ports: `a[3:0]`, `b[3:0]`, `cin` → `digit[3:0]`, `cout`.
- The controller instantiates exactly one `bcd_digit_adder`.

## Test plan
- Normal add, DIGITS=4: `a`=16'h1234, `b`=16'h5678, `start` pulse.
  - `done` exactly 6 cycles after `start`.
  - `sum`=16'h6912, `cout`=0, `err`=0.
- Full carry ripple: `a`=16'h9999, `b`=16'h0001.
  - `sum`=16'h0000, `cout`=1.
  - Per-digit carry propagates across all four ADD cycles.
- Zero and max digit: `a`=16'h0000, `b`=16'h0000 → `sum`=0, `cout`=0. Then `a`=16'h0009, `b`=16'h0009 → `sum`=16'h0018.
- Invalid digit: `a`=16'h00A0, `b`=16'h0001.
  - `err`=1, `sum`=16'hFFFF, `cout`=0.
  - `done` 2 cycles after `start`.
- Busy/hold rules: pulse `start` during ADD and change `a`/`b` mid-operation.
  - Result matches the operands captured at LOAD.
  - Exactly one `done`.
- Reset mid-ADD: assert `rst` during the second ADD cycle.
  - All outputs return to 0 asynchronously and state=IDLE.
  - A following `start` completes normally with correct `sum`.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encodings, BCD limits and seven-segment codes for the serial BCD adder
package bcd_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;
  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG3 = 7'b0110000;
  localparam logic [6:0] SEG4 = 7'b0011001;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEG6 = 7'b0000010;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] SEG8 = 7'b0000000;
  localparam logic [6:0] SEG9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// bcd_serial_adder_ctrl_if: start/busy/done handshake and operand/result bus of the serial BCD adder
interface bcd_serial_adder_ctrl_if #(parameter int DIGITS = 4);
  logic start;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] sum;
  logic cout;
  logic err;
  modport master(output start, a, b, input busy, done, sum, cout, err);
  modport slave(input start, a, b, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_serial_adder_ctrl_digit_adder.sv
// bcd_digit_adder: one-digit BCD adder built from a 4-bit ripple full-adder slice with >9 correction
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);
  logic [4:0] c;
  logic [3:0] s;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .s(s[i]), .cout(c[i+1]));
  end
  assign cout = {c[4], s} > {1'b0, BCD_MAX};
  assign digit = cout ? s + BCD_ADJ : s;
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: adds two packed BCD operands one digit per clock through a single shared digit adder
module bcd_serial_adder_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic CLOCK_50,
  input logic rst,
  bcd_serial_adder_ctrl_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state, nxt;
  logic [W-1:0] sa, sb, sum;
  logic [IW-1:0] idx;
  logic carry, cout, err, busy, done, bad, last, dcout;
  logic [3:0] digit;
  bcd_digit_adder u_add (.a(sa[3:0]), .b(sb[3:0]), .cin(carry), .digit(digit), .cout(dcout));
  assign last = idx == IW'(DIGITS - 1);
  assign bus.sum = sum;
  assign bus.cout = cout;
  assign bus.err = err;
  assign bus.busy = busy;
  assign bus.done = done;
  // flag any non-decimal digit in the operands being captured this LOAD cycle
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | digit_bad(bus.a[4*i +: 4]) | digit_bad(bus.b[4*i +: 4]);
  end
  // next-state: start only honoured in IDLE, invalid operands skip straight to DONE
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: nxt = bus.start ? ST_LOAD : ST_IDLE;
      ST_LOAD: nxt = bad ? ST_DONE : ST_ADD;
      ST_ADD:  nxt = last ? ST_DONE : ST_ADD;
      default: nxt = ST_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= nxt;
  end
  // datapath: capture operands at LOAD, then shift one digit per ADD cycle into the result slot
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      sum <= '0;
      idx <= '0;
      carry <= 1'b0;
      cout <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= nxt == ST_LOAD || nxt == ST_ADD;
      done <= nxt == ST_DONE;
      if (state == ST_LOAD) begin
        sa <= bus.a;
        sb <= bus.b;
        idx <= '0;
        carry <= 1'b0;
        cout <= 1'b0;
        err <= bad;
        sum <= bad ? '1 : '0;
      end else if (state == ST_ADD) begin
        sa <= sa >> 4;
        sb <= sb >> 4;
        sum[4*idx +: 4] <= digit;
        carry <= dcout;
        idx <= idx + 1'b1;
        if (last) cout <= dcout;
      end
    end
  end
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: directed vectors with a queue scoreboard checked by an independent done monitor
module tb_bcd_serial_adder_ctrl;
  import bcd_pkg::*;
  typedef struct {
    logic [15:0] sum;
    logic cout;
    logic err;
    int lat;
    int t0;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int ndone = 0;
  exp_t sq[$];
  bcd_serial_adder_ctrl_if #(.DIGITS(4)) bus ();
  bcd_serial_adder_ctrl #(.DIGITS(4)) dut (.CLOCK_50(clk), .rst(rst), .bus(bus));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.busy && bus.done) begin
        mismatched++;
        $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
      end
      if (bus.done) begin
        ndone++;
        if (sq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done: got done with empty scoreboard expected none");
        end else begin
          e = sq.pop_front();
          chk("sum", 32'(bus.sum), 32'(e.sum));
          chk("cout", 32'(bus.cout), 32'(e.cout));
          chk("err", 32'(bus.err), 32'(e.err));
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] es, input logic ec, input logic ee);
    @(negedge clk);
    bus.a = ta;
    bus.b = tb;
    bus.start = 1'b1;
    sq.push_back('{es, ec, ee, ee ? 2 : 6, cyc});
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && sq.size() > 0; i++) @(negedge clk);
    if (sq.size() > 0) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sq.size());
      sq.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask
  initial begin
    int n0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_sum", 32'(bus.sum), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    issue(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
    chk("busy_in_load", 32'(bus.busy), 32'h1);
    drain();
    issue(16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
    drain();
    issue(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    drain();
    issue(16'h0009, 16'h0009, 16'h0018, 1'b0, 1'b0);
    drain();
    issue(16'h00A0, 16'h0001, 16'hFFFF, 1'b0, 1'b1);
    drain();
    issue(16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0);
    drain();
    n0 = ndone;
    issue(16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'h9999;
    bus.b = 16'h9999;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    chk("single_done", 32'(ndone - n0), 32'h1);
    @(negedge clk);
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_sum", 32'(bus.sum), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_done", 32'(bus.done), 32'h0);
    chk("mid_rst_cout", 32'(bus.cout), 32'h0);
    chk("mid_rst_err", 32'(bus.err), 32'h0);
    chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(16'h0456, 16'h0789, 16'h1245, 1'b0, 1'b0);
    drain();
    issue(16'h0001, 16'h0009, 16'h0010, 1'b0, 1'b0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
